// File: rtl/mem_port_ctrl_if.sv
// Request/acknowledge and port-strobe bundle between the control unit, memory and mem_port_ctrl.
// master = requester/memory side, slave = the sequencer.
interface mem_port_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              ld_req;
    logic              st_req;
    logic [ADDR_W-1:0] addr_in;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic              mem_read;
    logic              wreg_load;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output ld_req, st_req, addr_in, mem_ack,
        input  mem_addr, mem_write, mem_read, wreg_load, busy, done, err
    );

    modport slave (
        input  ld_req, st_req, addr_in, mem_ack,
        output mem_addr, mem_write, mem_read, wreg_load, busy, done, err
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Working-register <-> data-bus port sequencer: round-robin load/store accept,
// bus-turnaround gap on direction change, ack wait with timeout, done/err pulses.
module mem_port_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = 15,
    parameter int TURN_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_ctrl_if.slave bus
);
    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam int TCW = $clog2(TURN_CYC + 1);

    localparam logic DIR_LD = 1'b0;
    localparam logic DIR_ST = 1'b1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TURN = 3'd1;
    localparam logic [2:0] S_LDW  = 3'd2;
    localparam logic [2:0] S_STW  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic              last_dir_q, last_dir_d;
    logic              gnt_last_q, gnt_last_d;
    logic              err_q, err_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [TCW-1:0]    turn_cnt_q, turn_cnt_d;

    logic              any_req;
    logic              acc_dir;
    logic              in_wait;
    logic [WCW-1:0]    wait_nxt;

    // On a simultaneous request the type not granted last time wins.
    assign any_req  = bus.ld_req | bus.st_req;
    assign acc_dir  = (bus.ld_req & bus.st_req) ? ~gnt_last_q : bus.st_req;
    assign in_wait  = (state_q == S_LDW) | (state_q == S_STW);
    assign wait_nxt = (wait_cnt_q == WCW'(WAIT_MAX)) ? wait_cnt_q : wait_cnt_q + WCW'(1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        gnt_last_d = gnt_last_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        turn_cnt_d = turn_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    addr_d     = bus.addr_in;
                    dir_d      = acc_dir;
                    gnt_last_d = acc_dir;
                    err_d      = 1'b0;
                    if (acc_dir != last_dir_q) begin
                        state_d    = S_TURN;
                        turn_cnt_d = '0;
                    end else begin
                        state_d    = (acc_dir == DIR_ST) ? S_STW : S_LDW;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_TURN: begin
                if (turn_cnt_q == TCW'(TURN_CYC - 1)) begin
                    state_d    = (dir_q == DIR_ST) ? S_STW : S_LDW;
                    last_dir_d = dir_q;
                    wait_cnt_d = '0;
                end else begin
                    turn_cnt_d = turn_cnt_q + TCW'(1);
                end
            end
            S_LDW, S_STW: begin
                wait_cnt_d = wait_nxt;
                // Ack on the final allowed cycle still counts as a success.
                if (bus.mem_ack) begin
                    state_d = S_FIN;
                end else if (wait_nxt == WCW'(WAIT_MAX)) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            dir_q      <= DIR_LD;
            last_dir_q <= DIR_LD;
            gnt_last_q <= DIR_LD;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            gnt_last_q <= gnt_last_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // Strobes decode straight from state so they can never overlap.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_write = (state_q == S_LDW);
    assign bus.mem_read  = (state_q == S_STW);
    assign bus.wreg_load = (state_q == S_LDW) & bus.mem_ack;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_FIN);
    assign bus.err       = (state_q == S_FIN) & err_q;

    logic unused_ok;
    assign unused_ok = in_wait;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a transaction-timeline reference model
// checked every cycle, plus literal latency/count expectations per scenario.
module tb_mem_port_ctrl;
    localparam int ADDR_W   = 16;
    localparam int WAIT_MAX = 15;
    localparam int TURN_CYC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    mem_port_ctrl #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX), .TURN_CYC(TURN_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Memory responder: acks ack_lat cycles into the strobe when enabled.
    bit ack_en    = 1'b1;
    int ack_lat   = 0;
    bit ack_force = 1'b0;
    initial begin
        int sc;
        sc = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_write || bus.mem_read) begin
                bus.mem_ack = ack_force || (ack_en && sc == ack_lat);
                sc++;
            end else begin
                bus.mem_ack = ack_force;
                sc = 0;
            end
        end
    end

    // Observed-event tallies, cleared by the stimulus per scenario.
    int n_w, n_r, n_wl, n_done, n_err, t_done, t_fs;
    task automatic clr();
        n_w = 0; n_r = 0; n_wl = 0; n_done = 0; n_err = 0; t_done = -1; t_fs = -1;
    endtask

    // Reference model: one transaction described by its accept cycle, strobe
    // window [m_ts, m_tend] and done cycle m_tfin (-1 while still unknown).
    bit              m_act = 0, m_dir = 0, m_err = 0, m_last = 0, m_gnt = 0, armed = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    int              m_ts = 0, m_tend = -1, m_tfin = -1;

    initial begin
        bit e_str, e_done;
        forever begin
            @(negedge clk);
            e_str  = m_act && cyc >= m_ts && (m_tend < 0 || cyc <= m_tend);
            e_done = m_act && cyc == m_tfin;
            if (armed) begin
                chk("busy",      32'(bus.busy),      32'(m_act));
                chk("mem_write", 32'(bus.mem_write), 32'(e_str && m_dir == 1'b0));
                chk("mem_read",  32'(bus.mem_read),  32'(e_str && m_dir == 1'b1));
                chk("wreg_load", 32'(bus.wreg_load), 32'(e_str && m_dir == 1'b0 && bus.mem_ack));
                chk("done",      32'(bus.done),      32'(e_done));
                chk("err",       32'(bus.err),       32'(e_done && m_err));
                chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
                if (bus.mem_write) n_w++;
                if (bus.mem_read)  n_r++;
                if (bus.wreg_load) n_wl++;
                if (bus.err)       n_err++;
                if ((bus.mem_write || bus.mem_read) && t_fs < 0) t_fs = cyc;
                if (bus.done) begin n_done++; t_done = cyc; end
            end
            if (rst) begin
                m_act = 0; m_addr = '0; m_last = 0; m_gnt = 0; armed = 1;
            end else if (m_act) begin
                if (e_str && bus.mem_ack) begin
                    m_tend = cyc; m_tfin = cyc + 1;
                end else if (e_str && cyc - m_ts + 1 == WAIT_MAX) begin
                    m_tend = cyc; m_tfin = cyc + 1; m_err = 1;
                end
                if (e_done) m_act = 0;
            end else if (bus.ld_req || bus.st_req) begin
                m_dir  = (bus.ld_req && bus.st_req) ? !m_gnt : bus.st_req;
                m_gnt  = m_dir;
                m_ts   = cyc + 1 + ((m_dir != m_last) ? TURN_CYC : 0);
                m_last = m_dir;
                m_tend = -1; m_tfin = -1; m_err = 0;
                m_addr = bus.addr_in;
                m_act  = 1;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the request until done, then drop it so the next IDLE cycle is free.
    task automatic xact(input bit ld, input bit st, input logic [ADDR_W-1:0] a, output int t0);
        clr();
        t0 = cyc;
        bus.ld_req = ld; bus.st_req = st; bus.addr_in = a;
        for (int k = 0; k < 100; k++) begin
            if (bus.done) break;
            tick();
        end
        chk("xact_done_seen", 32'(bus.done), 32'd1);
        bus.ld_req = 1'b0; bus.st_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        bit dirs [3];
        bit exp_dirs [3];
        exp_dirs[0] = 1'b1; exp_dirs[1] = 1'b0; exp_dirs[2] = 1'b1;
        bus.ld_req = 1'b0; bus.st_req = 1'b0; bus.addr_in = '0;
        clr();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_busy",     32'(bus.busy),      32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
        chk("rst_strobes",  32'({bus.mem_write, bus.mem_read}), 32'd0);
        chk("rst_pulses",   32'({bus.wreg_load, bus.done, bus.err}), 32'd0);

        // Load, ack in first strobe cycle.
        xact(1'b1, 1'b0, 16'h1234, t0);
        chk("ld_done_lat",   32'(t_done - t0), 32'd2);
        chk("ld_strobe_lat", 32'(t_fs - t0),   32'd1);
        chk("ld_wreg_cnt",   32'(n_wl),        32'd1);
        chk("ld_read_cnt",   32'(n_r),         32'd0);
        chk("ld_addr",       32'(bus.mem_addr), 32'h1234);

        // Direction change costs one turnaround cycle; same direction does not.
        xact(1'b0, 1'b1, 16'h2000, t0);
        chk("turn_done_lat",   32'(t_done - t0), 32'd3);
        chk("turn_strobe_lat", 32'(t_fs - t0),   32'd2);
        xact(1'b0, 1'b1, 16'h2001, t0);
        chk("same_done_lat",   32'(t_done - t0), 32'd2);

        // Round-robin on simultaneous requests after reset: STORE, LOAD, STORE.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xact(1'b1, 1'b1, 16'(16'h3000 + i), t0);
            dirs[i] = (n_r > 0);
            chk("rr_grant", 32'(dirs[i]), 32'(exp_dirs[i]));
            chk("rr_done",  32'(n_done),  32'd1);
        end

        // Store timeout: strobe high WAIT_MAX cycles, done+err together.
        ack_en = 1'b0;
        xact(1'b0, 1'b1, 16'h4000, t0);
        chk("to_read_cnt", 32'(n_r),    32'd15);
        chk("to_err_cnt",  32'(n_err),  32'd1);
        chk("to_done_cnt", 32'(n_done), 32'd1);
        chk("to_wreg_cnt", 32'(n_wl),   32'd0);
        chk("to_span",     32'(t_done - t_fs), 32'd15);

        // Reset in the third LD_WAIT cycle aborts silently.
        clr();
        bus.ld_req = 1'b1; bus.addr_in = 16'h5000;
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_write) break;
            tick();
        end
        chk("abort_strobe_seen", 32'(bus.mem_write), 32'd1);
        tick(2);
        rst = 1'b1; bus.ld_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_write", 32'(bus.mem_write), 32'd0);
        chk("abort_busy",  32'(bus.busy),      32'd0);
        tick(3);
        chk("abort_no_done", 32'(n_done), 32'd0);
        ack_en = 1'b1;
        xact(1'b1, 1'b0, 16'h00FF, t0);
        chk("post_abort_lat",  32'(t_done - t0),   32'd2);
        chk("post_abort_addr", 32'(bus.mem_addr),  32'h00FF);

        // Load pulse during a store is ignored.
        clr();
        ack_lat = 3;
        bus.st_req = 1'b1; bus.addr_in = 16'h6666;
        tick(2);
        bus.ld_req = 1'b1; bus.addr_in = 16'h7777;
        tick();
        bus.ld_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.done) break;
            tick();
        end
        bus.st_req = 1'b0;
        tick(4);
        chk("ign_done_cnt",  32'(n_done),       32'd1);
        chk("ign_write_cnt", 32'(n_w),          32'd0);
        chk("ign_addr",      32'(bus.mem_addr), 32'h6666);
        ack_lat = 0;

        // Stray ack while idle has no effect.
        clr();
        ack_force = 1'b1;
        tick(3);
        ack_force = 1'b0;
        tick();
        chk("idle_ack_wreg", 32'(n_wl),   32'd0);
        chk("idle_ack_done", 32'(n_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Sequencer for the working-register ⇄ data-bus bidirectional port.
- Accepts load/store requests from the control unit and arbitrates them when both arrive together.
- Drives the port direction strobes mem_write/mem_read, latches the address and waits for the memory acknowledge.
- Inserts a bus-turnaround gap on every direction change, pulses the working-register capture enable, and flags timeouts.

Parameters:
- ADDR_W, 16, width of request and memory address.
- WAIT_MAX, 15, max cycles a strobe stays active without mem_ack before timeout (≥1).
- TURN_CYC, 1, idle cycles inserted when bus direction changes (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ld_req  in  1  load request: bus data → working reg; sampled only in IDLE.
- st_req  in  1  store request: working reg → bus; sampled only in IDLE.
- addr_in  in  ADDR_W  request address, captured on accept.
- mem_ack  in  1  memory acknowledge, qualifies the current transfer.
- mem_addr  out  ADDR_W  latched address, held stable for the whole transaction.
- mem_write  out  1  port direction bus→wreg; high only in LD_WAIT.
- mem_read  out  1  port direction wreg→bus; high only in ST_WAIT.
- wreg_load  out  1  one-cycle working-register capture enable.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse, coincident with done.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, mem_addr=0, all 1-bit outputs 0, last_dir=LOAD, gnt_last=LOAD, counters 0.
- Reset mid-transaction: at the next edge, strobes drop, state returns to IDLE, and no done/err is issued.
- mem_write and mem_read are never both high. Both are low in IDLE, TURN and FINISH (port tri-stated).
- States:
  - IDLE: no request → stay. One request → accept.
    - Both requests → grant the type opposite gnt_last (round-robin); after reset the first conflict grants STORE.
    - On accept: latch addr_in into mem_addr, record dir and gnt_last.
    - If dir ≠ last_dir → TURN (turn counter=0), else → LD_WAIT or ST_WAIT directly.
  - TURN: strobes low; after TURN_CYC cycles → LD_WAIT or ST_WAIT. Update last_dir on exit.
  - LD_WAIT: mem_write=1, wait counter increments each cycle.
    - mem_ack=1 → wreg_load=1 in that same cycle (combinational on ack, while the port still drives) → FINISH.
    - Counter reaches WAIT_MAX without ack → FINISH with err flag set; no wreg_load.
  - ST_WAIT: mem_read=1.
    - mem_ack → FINISH.
    - Timeout → FINISH with err flag set.
  - FINISH: done=1 (err=1 if timed out), strobes low → IDLE.
- Requests are not queued. Requests present while busy=1 are ignored; the requester holds the request until it sees done.
- A request held high through FINISH is re-accepted in the IDLE cycle that follows.
- Latency, same direction, ack in the first strobe cycle:
  - req seen in IDLE at cycle 0;
  - strobe high cycle 1;
  - done cycle 2;
  - busy low cycle 3, new accept possible cycle 3.
  - A direction change adds TURN_CYC cycles.
- Timeout: the strobe is high for exactly WAIT_MAX cycles, then FINISH.
- mem_ack is ignored outside the WAIT states.
- The wait counter saturates and clears on entry to each WAIT state.

Test Plan:
- Reset, then load at addr 0x1234, mem_ack in 1st cycle → mem_write high cycle 1, wreg_load pulse cycle 1, done cycle 2, mem_addr=0x1234, mem_read never high.
- Load then store back-to-back (TURN_CYC=1) → store strobe delayed one idle cycle with both strobes low; 2nd done exactly 1 cycle later than a same-direction pair.
- ld_req and st_req high together three times after reset → grants STORE, LOAD, STORE; each done observed.
- Store with mem_ack never asserted, WAIT_MAX=15 → mem_read high exactly 15 cycles, then done=1 and err=1 for one cycle, no wreg_load.
- rst asserted during LD_WAIT cycle 3 → next cycle mem_write=0, busy=0, no done. A following load at 0x00FF (last_dir=LOAD) completes without a TURN cycle.
- Pulse ld_req while busy with a store → ignored: no second transaction, mem_addr unchanged.
